tx_pkt_scheduler: RTL and testbench

TX_PKT_SCHEDULER -- requirements
Module: tx_pkt_scheduler

---
 rtl/tx_pkt_scheduler.sv | 150 +++++++++++++++
 tb/tb_tx_pkt_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_scheduler.sv
// tx_pkt_scheduler: round-robin launcher for token and data packets into the
// CRC5/CRC16 encoders. Exactly one packet is in flight: launch, wait for the
// line encoder to report it sent (or time out), then hold off for an
// inter-packet gap before accepting the next request.
module tx_pkt_scheduler #(
  parameter int unsigned IPG_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tok_req,
  input  logic [18:0] tok_pkt,
  input  logic        data_req,
  input  logic [71:0] data_pkt,
  input  logic        sent,
  output logic        tok_grant,
  output logic        data_grant,
  output logic        crc5_pkt_ready,
  output logic [18:0] crc5_pkt_in,
  output logic        crc16_pkt_ready,
  output logic [71:0] crc16_pkt_in,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_SENT = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  // Abort fires on the TIMEOUT_CYCLES-th WAIT_SENT cycle without sent.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(IPG_CYCLES - 1);

  state_t      r_state;
  logic        r_last_data;   // 1: data was served last, so token is favoured
  logic [15:0] r_wait_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_tok_grant;
  logic        r_data_grant;
  logic        r_crc5_ready;
  logic        r_crc16_ready;
  logic [18:0] r_crc5_pkt;
  logic [71:0] r_crc16_pkt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_pick_tok;
  logic        w_any_req;
  logic        w_wait_sat;

  // Arbitration: a lone requester wins; on contention the one not served last.
  always_comb begin
    w_any_req  = tok_req | data_req;
    w_pick_tok = tok_req & (~data_req | r_last_data);
    w_wait_sat = &r_wait_cnt;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_data   <= 1'b1;
      r_wait_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_tok_grant   <= 1'b0;
      r_data_grant  <= 1'b0;
      r_crc5_ready  <= 1'b0;
      r_crc16_ready <= 1'b0;
      r_crc5_pkt    <= '0;
      r_crc16_pkt   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_tok_grant   <= 1'b0;
      r_data_grant  <= 1'b0;
      r_crc5_ready  <= 1'b0;
      r_crc16_ready <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_LAUNCH;
            r_busy  <= 1'b1;
            if (w_pick_tok) begin
              r_crc5_pkt   <= tok_pkt;
              r_tok_grant  <= 1'b1;
              r_crc5_ready <= 1'b1;
              r_last_data  <= 1'b0;
            end else begin
              r_crc16_pkt   <= data_pkt;
              r_data_grant  <= 1'b1;
              r_crc16_ready <= 1'b1;
              r_last_data   <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_state    <= S_WAIT_SENT;
          r_wait_cnt <= '0;
        end
        S_WAIT_SENT: begin
          if (sent) begin
            r_done    <= 1'b1;
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
          end else if (r_wait_cnt == TO_LAST) begin
            r_err     <= 1'b1;
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
          end else if (!w_wait_sat) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports straight from the output registers.
  always_comb begin
    tok_grant       = r_tok_grant;
    data_grant      = r_data_grant;
    crc5_pkt_ready  = r_crc5_ready;
    crc5_pkt_in     = r_crc5_pkt;
    crc16_pkt_ready = r_crc16_ready;
    crc16_pkt_in    = r_crc16_pkt;
    busy            = r_busy;
    done            = r_done;
    err_timeout     = r_err;
  end

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// Directed bench for tx_pkt_scheduler with a scoreboard: stimulus pushes the
// expected output events, a monitor pops and compares them as they appear.
module tb_tx_pkt_scheduler;

  localparam int unsigned IPG = 4;
  localparam int unsigned TO  = 8;

  localparam int unsigned K_TOK  = 0;
  localparam int unsigned K_DATA = 1;
  localparam int unsigned K_DONE = 2;
  localparam int unsigned K_TO   = 3;

  logic        clock;
  logic        reset_n;
  logic        tok_req;
  logic [18:0] tok_pkt;
  logic        data_req;
  logic [71:0] data_pkt;
  logic        sent;
  logic        tok_grant;
  logic        data_grant;
  logic        crc5_pkt_ready;
  logic [18:0] crc5_pkt_in;
  logic        crc16_pkt_ready;
  logic [71:0] crc16_pkt_in;
  logic        busy;
  logic        done;
  logic        err_timeout;

  typedef struct {
    int unsigned kind;
    logic [71:0] pkt;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tx_pkt_scheduler #(
    .IPG_CYCLES    (IPG),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .tok_req        (tok_req),
    .tok_pkt        (tok_pkt),
    .data_req       (data_req),
    .data_pkt       (data_pkt),
    .sent           (sent),
    .tok_grant      (tok_grant),
    .data_grant     (data_grant),
    .crc5_pkt_ready (crc5_pkt_ready),
    .crc5_pkt_in    (crc5_pkt_in),
    .crc16_pkt_ready(crc16_pkt_ready),
    .crc16_pkt_in   (crc16_pkt_in),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push(input int unsigned kind, input logic [71:0] pkt);
    exp_t e;
    e.kind = kind;
    e.pkt  = pkt;
    sb_q.push_back(e);
  endtask

  function automatic logic [97:0] all_out();
    return {tok_grant, data_grant, crc5_pkt_ready, crc5_pkt_in, crc16_pkt_ready,
            crc16_pkt_in, busy, done, err_timeout};
  endfunction

  task automatic mon_pop(input int unsigned kind, input logic [71:0] pkt);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: got event kind %0d expected none", kind);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == K_TOK || kind == K_DATA) chk("sb_pkt", pkt, e.pkt);
    end
  endtask

  // Monitor: every presented output event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (tok_grant || data_grant || done || err_timeout) begin
        chk("one_hot_events", 32'($countones({tok_grant, data_grant, done, err_timeout})), 1);
        chk("ready_matches_grant", {crc5_pkt_ready, crc16_pkt_ready}, {tok_grant, data_grant});
      end
      if (tok_grant)   mon_pop(K_TOK, {53'd0, crc5_pkt_in});
      if (data_grant)  mon_pop(K_DATA, crc16_pkt_in);
      if (done)        mon_pop(K_DONE, '0);
      if (err_timeout) mon_pop(K_TO, '0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1);
  end

  // From the LAUNCH cycle: raise sent on WAIT_SENT cycle w, expect done next.
  task automatic complete(input int unsigned w);
    repeat (w + 1) tick();
    sent = 1'b1;
    push(K_DONE, '0);
    tick();
    chk("done_pulse", done, 1'b1);
    chk("no_err_on_done", err_timeout, 1'b0);
    sent = 1'b0;
  endtask

  // From the first GAP cycle: busy for IPG cycles total, then IDLE.
  task automatic gap_check();
    for (int i = 1; i < int'(IPG); i++) begin
      tick();
      chk("gap_busy", busy, 1'b1);
      chk("gap_no_done", done, 1'b0);
      chk("gap_no_err", err_timeout, 1'b0);
    end
    tick();
    chk("idle_after_gap", busy, 1'b0);
  endtask

  task automatic wait_grant(input bit exp_tok);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tok_grant || data_grant) break;
    end
    chk("grant_type", {tok_grant, data_grant}, exp_tok ? 2'b10 : 2'b01);
  endtask

  initial begin
    logic [71:0] p_data;
    logic [18:0] t1, t2, t3, t4, t5, t6;
    logic [71:0] d1, d2, d3;
    p_data = 72'he46700001b981111C3;
    t1 = 19'h2D2A5; t2 = 19'h15A5A; t3 = 19'h7FFFF;
    t4 = 19'h00001; t5 = 19'h40000; t6 = 19'h3C3C3;
    d1 = 72'h0123456789ABCDEF5A;
    d2 = 72'hFFEEDDCCBBAA99884B;
    d3 = 72'h800000000000000169;

    reset_n = 1'b0; tok_req = 1'b0; tok_pkt = '0;
    data_req = 1'b0; data_pkt = '0; sent = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", all_out(), '0);
    reset_n = 1'b1;
    tick();

    // Data only
    data_req = 1'b1; data_pkt = p_data;
    push(K_DATA, p_data);
    tick();
    chk("data_grant", data_grant, 1'b1);
    chk("crc16_ready", crc16_pkt_ready, 1'b1);
    chk("crc16_pkt", crc16_pkt_in, p_data);
    chk("tok_idle_on_data", {tok_grant, crc5_pkt_ready}, 2'b00);
    chk("busy_launch", busy, 1'b1);
    data_req = 1'b0; data_pkt = '0;
    complete(2);
    chk("crc16_hold", crc16_pkt_in, p_data);
    gap_check();

    // Simultaneous after reset: token first, data after GAP
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tok_req = 1'b1; tok_pkt = t1; data_req = 1'b1; data_pkt = d1;
    push(K_TOK, {53'd0, t1});
    tick();
    chk("tok_first", {tok_grant, crc5_pkt_ready, data_grant, crc16_pkt_ready}, 4'b1100);
    chk("crc5_pkt", crc5_pkt_in, t1);
    chk("crc16_cleared", crc16_pkt_in, 72'd0);
    tok_req = 1'b0;
    complete(3);
    push(K_DATA, d1);
    for (int i = 1; i <= int'(IPG); i++) begin
      tick();
      chk("data_held_off", data_grant, 1'b0);
    end
    tick();
    chk("data_after_gap", data_grant, 1'b1);
    chk("crc16_pkt2", crc16_pkt_in, d1);
    chk("crc5_hold", crc5_pkt_in, t1);
    data_req = 1'b0;
    complete(0);
    gap_check();

    // Alternation with both requesters kept busy
    tok_req = 1'b1; tok_pkt = t2; data_req = 1'b1; data_pkt = d2;
    push(K_TOK, {53'd0, t2});
    tick();
    chk("alt_tok", tok_grant, 1'b1);
    tok_pkt = t3;
    complete(1);
    push(K_DATA, d2);
    wait_grant(1'b0);
    data_req = 1'b0;
    complete(1);
    push(K_TOK, {53'd0, t3});
    wait_grant(1'b1);
    tok_req = 1'b0;
    complete(0);
    gap_check();

    // Timeout abort
    tok_req = 1'b1; tok_pkt = t4;
    push(K_TOK, {53'd0, t4});
    tick();
    chk("to_launch", tok_grant, 1'b1);
    tok_req = 1'b0;
    for (int i = 1; i <= int'(TO); i++) begin
      tick();
      chk("no_early_timeout", err_timeout, 1'b0);
    end
    push(K_TO, '0);
    tick();
    chk("timeout_pulse", err_timeout, 1'b1);
    chk("timeout_no_done", done, 1'b0);
    chk("timeout_busy", busy, 1'b1);
    gap_check();

    // sent on the last permitted WAIT_SENT cycle: completion wins
    tok_req = 1'b1; tok_pkt = t5;
    push(K_TOK, {53'd0, t5});
    tick();
    chk("bnd_launch", tok_grant, 1'b1);
    tok_req = 1'b0;
    complete(TO - 1);
    gap_check();

    // Spurious sent in IDLE, LAUNCH and GAP
    sent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_sent_ignored", {busy, done}, 2'b00);
    end
    sent = 1'b0;
    data_req = 1'b1; data_pkt = d3;
    push(K_DATA, d3);
    tick();
    chk("data_launch3", data_grant, 1'b1);
    data_req = 1'b0;
    sent = 1'b1;
    tick();
    chk("launch_sent_ignored", {done, busy}, 2'b01);
    sent = 1'b0;
    complete(1);
    sent = 1'b1;
    gap_check();
    sent = 1'b0;

    // Asynchronous reset in WAIT_SENT
    tok_req = 1'b1; tok_pkt = t6;
    push(K_TOK, {53'd0, t6});
    tick();
    chk("rst_launch", tok_grant, 1'b1);
    tok_req = 1'b0;
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), '0);
    tok_req = 1'b1; tok_pkt = t2;
    tick();
    chk("held_reset_outputs", all_out(), '0);
    reset_n = 1'b1;
    push(K_TOK, {53'd0, t2});
    tick();
    chk("post_reset_grant", {tok_grant, crc5_pkt_ready}, 2'b11);
    chk("post_reset_pkt", crc5_pkt_in, t2);
    tok_req = 1'b0;
    complete(0);
    gap_check();

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
